// File: rtl/adcv_pkg.sv
// -----------------------------------------------------------------------------
// adcv_pkg
// Shared definitions for the ramp/TDC ADC conversion sequencer:
//   - default code width, averaging depth and settle count
//   - sequencer state encoding
//   - saturation detect for raw TDC codes
// -----------------------------------------------------------------------------
package adcv_pkg;

  localparam int ADCV_CODE_BITS      = 7;
  localparam int ADCV_AVG_LOG2       = 3;
  localparam int ADCV_SETTLE_DEFAULT = 2;

  typedef enum logic [1:0] {
    ADCV_IDLE   = 2'd0,
    ADCV_SETTLE = 2'd1,
    ADCV_ACCUM  = 2'd2,
    ADCV_OUTPUT = 2'd3
  } adcv_state_e;

  // A code is saturated when it sits on either rail of a bits-wide range.
  // The code is passed zero-extended so one function serves any width <= 16.
  function automatic logic adcv_is_sat(input logic [15:0] code,
                                       input int unsigned bits);
    logic [15:0] full_scale;
    full_scale = 16'((32'd1 << bits) - 32'd1);
    return (code == 16'd0) || (code == full_scale);
  endfunction

endpackage

// File: rtl/adcv_avg_accum.sv
// -----------------------------------------------------------------------------
// adcv_avg_accum
// Running sum, sample counter and saturation flag for one averaging window.
// Ports:
//   clock_i, reset_i : clock, synchronous active-high reset
//   clear_i          : start a fresh window (priority over add_i)
//   add_i            : accumulate code_i this cycle
//   code_i           : raw code to accumulate
//   avg_o            : (sum including code_i) >> AVG_LOG2, truncated
//   sat_o            : sat flag of the window including code_i
//   done_o           : add_i is the last sample of the window
// -----------------------------------------------------------------------------
module adcv_avg_accum
  import adcv_pkg::*;
#(
  parameter int CODE_BITS = ADCV_CODE_BITS,
  parameter int AVG_LOG2  = ADCV_AVG_LOG2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic [CODE_BITS-1:0] code_i,
  output logic [CODE_BITS-1:0] avg_o,
  output logic                 sat_o,
  output logic                 done_o
);

  // 2^AVG_LOG2 codes of CODE_BITS each cannot exceed CODE_BITS+AVG_LOG2 bits.
  localparam int SUM_W = CODE_BITS + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic [SUM_W-1:0] sum_d;

  // Result and flag are presented including the current code so the top can
  // register them on the very strobe that completes the window.
  assign sum_d  = acc_q + SUM_W'(code_i);
  assign avg_o  = sum_d[SUM_W-1:AVG_LOG2];
  assign sat_o  = sat_q | adcv_is_sat(16'(code_i), CODE_BITS);
  assign done_o = add_i && (cnt_q == LAST_IDX);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register sees the pre-edge value of its neighbours.
  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (add_i) begin
      acc_q <= sum_d;
      cnt_q <= cnt_q + 1'b1;
      sat_q <= sat_o;
    end
  end

endmodule

// File: rtl/adcv_conv_sequencer.sv
// -----------------------------------------------------------------------------
// adcv_conv_sequencer
// Conversion sequencer for the ramp/TDC ADC (48 MHz TDC clock domain).
// Discards SETTLE ramp periods after start, averages 2^AVG_LOG2 raw codes and
// offers the result on a valid/ready handshake; counts strobes dropped while a
// continuous-mode result waits.
// Ports:
//   clock_i, reset_i      : clock, synchronous active-high reset
//   start_i, continuous_i : conversion request, free-running mode select
//   stop_i                : leave continuous mode after the current result
//   raw_code_i/raw_valid_i: TDC code and its per-ramp strobe
//   busy_o                : not IDLE
//   result_o/result_ovr_o : averaged code, saturation seen in the window
//   result_valid_o/result_ready_i : result handshake
//   overrun_cnt_o         : dropped strobes in continuous mode, saturating
// -----------------------------------------------------------------------------
module adcv_conv_sequencer
  import adcv_pkg::*;
#(
  parameter int CODE_BITS = ADCV_CODE_BITS,
  parameter int AVG_LOG2  = ADCV_AVG_LOG2,
  parameter int SETTLE    = ADCV_SETTLE_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 continuous_i,
  input  logic                 stop_i,
  input  logic [CODE_BITS-1:0] raw_code_i,
  input  logic                 raw_valid_i,
  output logic                 busy_o,
  output logic [CODE_BITS-1:0] result_o,
  output logic                 result_ovr_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [7:0]           overrun_cnt_o
);

  localparam logic [7:0] SETTLE_LAST = 8'((SETTLE > 0) ? SETTLE - 1 : 0);

  adcv_state_e          state_q, state_d;
  logic                 cont_q, cont_d;
  logic                 busy_q, busy_d;
  logic [7:0]           settle_q, settle_d;
  logic [CODE_BITS-1:0] result_q, result_d;
  logic                 ovr_q, ovr_d;
  logic                 valid_q, valid_d;
  logic [7:0]           overrun_q, overrun_d;

  logic                 acc_clear, acc_add, acc_done, acc_sat;
  logic [CODE_BITS-1:0] acc_avg;

  adcv_avg_accum #(
    .CODE_BITS (CODE_BITS),
    .AVG_LOG2  (AVG_LOG2)
  ) u_accum (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (acc_clear),
    .add_i   (acc_add),
    .code_i  (raw_code_i),
    .avg_o   (acc_avg),
    .sat_o   (acc_sat),
    .done_o  (acc_done)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d   = state_q;
    cont_d    = cont_q & ~stop_i;
    settle_d  = settle_q;
    result_d  = result_q;
    ovr_d     = ovr_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;

    unique case (state_q)
      ADCV_IDLE: begin
        if (start_i) begin
          // start together with stop yields a single conversion
          cont_d    = continuous_i & ~stop_i;
          overrun_d = '0;
          settle_d  = '0;
          acc_clear = 1'b1;
          state_d   = (SETTLE > 0) ? ADCV_SETTLE : ADCV_ACCUM;
        end
      end
      ADCV_SETTLE: begin
        if (raw_valid_i) begin
          if (settle_q == SETTLE_LAST) state_d = ADCV_ACCUM;
          else                         settle_d = settle_q + 8'd1;
        end
      end
      ADCV_ACCUM: begin
        acc_add = raw_valid_i;
        if (acc_done) begin
          result_d = acc_avg;
          ovr_d    = acc_sat;
          valid_d  = 1'b1;
          state_d  = ADCV_OUTPUT;
        end
      end
      ADCV_OUTPUT: begin
        // Strobes here are discarded, including the handshake cycle itself.
        if (raw_valid_i && cont_q && (overrun_q != 8'hFF))
          overrun_d = overrun_q + 8'd1;
        if (valid_q && result_ready_i) begin
          valid_d = 1'b0;
          if (cont_q) begin
            acc_clear = 1'b1;
            state_d   = ADCV_ACCUM;
          end else begin
            state_d   = ADCV_IDLE;
          end
        end
      end
      default: state_d = ADCV_IDLE;
    endcase

    busy_d = (state_d != ADCV_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ADCV_IDLE;
      cont_q    <= 1'b0;
      busy_q    <= 1'b0;
      settle_q  <= '0;
      result_q  <= '0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      cont_q    <= cont_d;
      busy_q    <= busy_d;
      settle_q  <= settle_d;
      result_q  <= result_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_ovr_o   = ovr_q;
  assign result_valid_o = valid_q;
  assign overrun_cnt_o  = overrun_q;

endmodule

// File: tb/tb_adcv_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adcv_conv_sequencer
// Self-checking bench: a table of single conversions (SETTLE=2, AVG_LOG2=3)
// followed by hand-written sequences for continuous mode, overrun, stop,
// ignored start and mid-conversion reset; a second instance with AVG_LOG2=0,
// SETTLE=0 covers the pass-through boundary.
// -----------------------------------------------------------------------------
module tb_adcv_conv_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (defaults: CODE_BITS=7, AVG_LOG2=3, SETTLE=2)
  logic       reset, start, continuous, stop, raw_valid, result_ready;
  logic [6:0] raw_code;
  logic       busy, result_ovr, result_valid;
  logic [6:0] result;
  logic [7:0] overrun_cnt;

  // Pass-through instance (AVG_LOG2=0, SETTLE=0)
  logic       a0_start, a0_raw_valid, a0_ready;
  logic [6:0] a0_raw_code;
  logic       a0_busy, a0_ovr, a0_valid;
  logic [6:0] a0_result;
  logic [7:0] a0_overrun;

  adcv_conv_sequencer dut (
    .clock_i        (clock),
    .reset_i        (reset),
    .start_i        (start),
    .continuous_i   (continuous),
    .stop_i         (stop),
    .raw_code_i     (raw_code),
    .raw_valid_i    (raw_valid),
    .busy_o         (busy),
    .result_o       (result),
    .result_ovr_o   (result_ovr),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .overrun_cnt_o  (overrun_cnt)
  );

  adcv_conv_sequencer #(.CODE_BITS(7), .AVG_LOG2(0), .SETTLE(0)) dut_a0 (
    .clock_i        (clock),
    .reset_i        (reset),
    .start_i        (a0_start),
    .continuous_i   (1'b0),
    .stop_i         (1'b0),
    .raw_code_i     (a0_raw_code),
    .raw_valid_i    (a0_raw_valid),
    .busy_o         (a0_busy),
    .result_o       (a0_result),
    .result_ovr_o   (a0_ovr),
    .result_valid_o (a0_valid),
    .result_ready_i (a0_ready),
    .overrun_cnt_o  (a0_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [6:0] c);
    raw_code  = c;
    raw_valid = 1'b1;
    tick();
    raw_valid = 1'b0;
  endtask

  task automatic strobe_n(input int n, input logic [6:0] c);
    for (int i = 0; i < n; i++) strobe(c);
  endtask

  task automatic pulse_start(input logic cont);
    continuous = cont;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic a0_conv(input logic [6:0] c, input logic exp_ovr);
    a0_start = 1'b1;
    tick();
    a0_start = 1'b0;
    check("a0_busy_after_start", 32'(a0_busy), 32'd1);
    a0_raw_code  = c;
    a0_raw_valid = 1'b1;
    tick();
    a0_raw_valid = 1'b0;
    check("a0_valid", 32'(a0_valid), 32'd1);
    check("a0_result", 32'(a0_result), 32'(c));
    check("a0_ovr", 32'(a0_ovr), 32'(exp_ovr));
    tick();
    check("a0_valid_drop", 32'(a0_valid), 32'd0);
    check("a0_busy_drop", 32'(a0_busy), 32'd0);
  endtask

  typedef struct {
    string          name;
    logic [7:0][6:0] codes;
    logic [6:0]     exp_res;
    logic           exp_ovr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"flat20",   {8{7'd20}}, 7'd20, 1'b0};
    vecs[1] = '{"trunc",    {7'd2, {7{7'd1}}}, 7'd1, 1'b0};         // 9/8
    vecs[2] = '{"top_rail", {{7{7'd10}}, 7'd127}, 7'd24, 1'b1};     // 197/8
    vecs[3] = '{"low_rail", {{7{7'd5}}, 7'd0}, 7'd4, 1'b1};         // 35/8
    vecs[4] = '{"ramp",     {7'd107, 7'd106, 7'd105, 7'd104,
                             7'd103, 7'd102, 7'd101, 7'd100}, 7'd103, 1'b0}; // 828/8
    vecs[5] = '{"near_top", {8{7'd126}}, 7'd126, 1'b0};
    vecs[6] = '{"near_low", {8{7'd1}}, 7'd1, 1'b0};

    reset = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
    raw_valid = 1'b0; raw_code = '0; result_ready = 1'b1;
    a0_start = 1'b0; a0_raw_valid = 1'b0; a0_raw_code = '0; a0_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovr", 32'(result_ovr), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);

    // Pass-through boundary: each ACCUM strobe is its own result.
    a0_conv(7'd77, 1'b0);
    a0_conv(7'd127, 1'b1);

    // Table: single conversions with two discarded settle codes.
    foreach (vecs[i]) begin
      pulse_start(1'b0);
      check({vecs[i].name, "_busy"}, 32'(busy), 32'd1);
      strobe(7'd10);
      strobe(7'd11);
      for (int k = 0; k < 7; k++) strobe(vecs[i].codes[k]);
      check({vecs[i].name, "_early_valid"}, 32'(result_valid), 32'd0);
      strobe(vecs[i].codes[7]);
      check({vecs[i].name, "_valid"}, 32'(result_valid), 32'd1);
      check({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].exp_res));
      check({vecs[i].name, "_ovr"}, 32'(result_ovr), 32'(vecs[i].exp_ovr));
      tick();
      check({vecs[i].name, "_valid_drop"}, 32'(result_valid), 32'd0);
      check({vecs[i].name, "_busy_drop"}, 32'(busy), 32'd0);
    end

    // Continuous mode with back-pressure.
    result_ready = 1'b0;
    pulse_start(1'b1);
    strobe(7'd10);
    strobe(7'd11);
    strobe_n(8, 7'd40);
    check("cont_valid1", 32'(result_valid), 32'd1);
    check("cont_result1", 32'(result), 32'd40);
    strobe_n(5, 7'd99);
    check("cont_overrun5", 32'(overrun_cnt), 32'd5);
    check("cont_result_hold", 32'(result), 32'd40);
    check("cont_valid_hold", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("cont_valid_drop", 32'(result_valid), 32'd0);
    check("cont_busy", 32'(busy), 32'd1);
    strobe_n(8, 7'd60);
    check("cont_valid2", 32'(result_valid), 32'd1);
    check("cont_result2_fresh", 32'(result), 32'd60);
    check("cont_ovr2", 32'(result_ovr), 32'd0);

    // Overrun saturation, then stop ends continuous mode after this result.
    strobe_n(300, 7'd99);
    check("overrun_sat", 32'(overrun_cnt), 32'd255);
    check("overrun_result_hold", 32'(result), 32'd60);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    result_ready = 1'b1;
    tick();
    check("stop_out_busy", 32'(busy), 32'd0);
    check("stop_out_valid", 32'(result_valid), 32'd0);
    check("overrun_idle_hold", 32'(overrun_cnt), 32'd255);
    pulse_start(1'b0);
    check("overrun_cleared", 32'(overrun_cnt), 32'd0);
    strobe(7'd10);
    strobe(7'd11);
    strobe_n(8, 7'd50);
    check("after_clear_result", 32'(result), 32'd50);
    tick();
    check("after_clear_busy", 32'(busy), 32'd0);

    // stop mid-ACCUM in continuous mode; a start while busy is ignored.
    pulse_start(1'b1);
    strobe(7'd10);
    strobe(7'd11);
    strobe_n(4, 7'd30);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pulse_start(1'b1);
    check("busy_start_ignored", 32'(busy), 32'd1);
    strobe_n(4, 7'd30);
    check("stop_valid", 32'(result_valid), 32'd1);
    check("stop_result", 32'(result), 32'd30);
    tick();
    check("stop_valid_drop", 32'(result_valid), 32'd0);
    check("stop_idle", 32'(busy), 32'd0);

    // Reset after 4 of 8 samples discards the partial window.
    pulse_start(1'b0);
    strobe(7'd10);
    strobe(7'd11);
    strobe_n(4, 7'd100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(result_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ovr", 32'(result_ovr), 32'd0);
    check("midrst_overrun", 32'(overrun_cnt), 32'd0);
    pulse_start(1'b0);
    strobe(7'd10);
    strobe(7'd11);
    strobe_n(7, 7'd10);
    check("postrst_early_valid", 32'(result_valid), 32'd0);
    strobe(7'd10);
    check("postrst_valid", 32'(result_valid), 32'd1);
    check("postrst_result", 32'(result), 32'd10);
    tick();
    check("postrst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
